// File: rtl/topo2a_ad_proj_mul_pipe.sv
// Pipelined projection-layer multiplier: per-transaction sign mode, round-half-up rescale,
// saturate or wrap to the output width, valid/ready handshake with full-pipeline stall.
module topo2a_ad_proj_mul_pipe #(
  parameter int unsigned din0_WIDTH = 15,
  parameter int unsigned din1_WIDTH = 6,
  parameter int unsigned dout_WIDTH = 20,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned SHIFT      = 0,
  parameter bit          SAT        = 1'b1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [1:0]            sign_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P  = int'(din0_WIDTH + din1_WIDTH) + 1;
  localparam int NS = int'(NUM_STAGE);
  localparam int W  = int'(dout_WIDTH);

  localparam logic signed [P:0] ONE  = {{P{1'b0}}, 1'b1};
  localparam logic signed [P:0] HALF = (ONE <<< SHIFT) >>> 1;
  localparam logic signed [P:0] SMAX = (ONE <<< (W - 1)) - ONE;
  localparam logic signed [P:0] SMIN = -(ONE <<< (W - 1));
  localparam logic signed [P:0] UMAX = (ONE <<< W) - ONE;

  logic            run_q;
  logic            advance;
  logic            accept;
  logic [NS-1:0]   vld_q;
  logic signed [P-1:0] a_ext, b_ext, prod;
  logic            rs_in;
  logic signed [P-1:0] sat_p;
  logic            sat_rs;
  logic            sat_v;
  logic signed [P:0] pe, r;
  logic            hi, lo;
  logic [W-1:0]    sat_dout;
  logic            sat_ovf;

  // Reset release is re-timed so nothing is accepted before the first edge after release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  assign out_valid = vld_q[NS-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && run_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    a_ext = {{(P - int'(din0_WIDTH)){sign_mode[0] & din0[din0_WIDTH-1]}}, din0};
    b_ext = {{(P - int'(din1_WIDTH)){sign_mode[1] & din1[din1_WIDTH-1]}}, din1};
    prod  = a_ext * b_ext;
    rs_in = |sign_mode;
  end

  generate
    if (NS == 1) begin : g_single
      assign sat_p  = prod;
      assign sat_rs = rs_in;
      assign sat_v  = accept;
    end else begin : g_multi
      logic signed [P-1:0] p_q [NS-1];
      logic [NS-2:0]       rs_q;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NS - 1; i++) p_q[i] <= '0;
          rs_q <= '0;
        end else if (advance) begin
          p_q[0]  <= prod;
          rs_q[0] <= rs_in;
          for (int i = 1; i < NS - 1; i++) begin
            p_q[i]  <= p_q[i-1];
            rs_q[i] <= rs_q[i-1];
          end
        end
      end

      assign sat_p  = p_q[NS-2];
      assign sat_rs = rs_q[NS-2];
      assign sat_v  = vld_q[NS-2];
    end
  endgenerate

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    pe = {sat_p[P-1], sat_p};
    r  = (pe + HALF) >>> SHIFT;
    if (sat_rs) begin
      hi = r > SMAX;
      lo = r < SMIN;
    end else begin
      hi = r > UMAX;
      lo = r[P];
    end
    sat_ovf = hi || lo;
    if (SAT && hi)      sat_dout = sat_rs ? SMAX[W-1:0] : UMAX[W-1:0];
    else if (SAT && lo) sat_dout = sat_rs ? SMIN[W-1:0] : '0;
    else                sat_dout = r[W-1:0];
  end

  // Result registers only load on a valid slot so bubbles leave the last result in place.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
    end else if (advance) begin
      vld_q[0] <= accept;
      for (int i = 1; i < NS; i++) vld_q[i] <= vld_q[i-1];
      if (sat_v) begin
        dout <= sat_dout;
        ovf  <= sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_topo2a_ad_proj_mul_pipe.sv
// Directed bench for topo2a_ad_proj_mul_pipe: default, rounding (SHIFT=4) and wrap (SAT=0) builds
// share one stimulus stream.
module tb_topo2a_ad_proj_mul_pipe;

  logic        clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [14:0] din0;
  logic [5:0]  din1;
  logic [1:0]  sign_mode;

  logic        in_ready_d, out_valid_d, ovf_d;
  logic [19:0] dout_d;
  logic        in_ready_r, out_valid_r, ovf_r;
  logic [19:0] dout_r;
  logic        in_ready_w, out_valid_w, ovf_w;
  logic [19:0] dout_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  topo2a_ad_proj_mul_pipe u_def (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
    .din0(din0), .din1(din1), .sign_mode(sign_mode), .out_valid(out_valid_d),
    .out_ready(out_ready), .dout(dout_d), .ovf(ovf_d)
  );

  topo2a_ad_proj_mul_pipe #(.SHIFT(4)) u_rnd (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .din0(din0), .din1(din1), .sign_mode(sign_mode), .out_valid(out_valid_r),
    .out_ready(out_ready), .dout(dout_r), .ovf(ovf_r)
  );

  topo2a_ad_proj_mul_pipe #(.SAT(1'b0)) u_wrap (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .din0(din0), .din1(din1), .sign_mode(sign_mode), .out_valid(out_valid_w),
    .out_ready(out_ready), .dout(dout_w), .ovf(ovf_w)
  );

  // Sends one operand pair and returns at the negedge where out_valid first shows,
  // with lat = number of cycles after the accepting edge.
  task automatic xact(input logic [14:0] a, input logic [5:0] b, input logic [1:0] sm,
                      output int lat);
    int n;
    @(negedge clk);
    din0 = a; din1 = b; sign_mode = sm; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready_d && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid_d && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; sign_mode = '0;
    #12;
    checks++; if (out_valid_d !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid_d); end
    checks++; if (dout_d !== 20'd0) begin errors++; $display("FAIL reset dout: got %0d expected 0", dout_d); end
    checks++; if (ovf_d !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b expected 0", ovf_d); end
    checks++; if (in_ready_d !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready_d); end
    @(negedge clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_unsigned_sat;
    int lat;
    xact(15'd32767, 6'd63, 2'b00, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL unsigned_max latency: got %0d expected 3", lat); end
    checks++; if (dout_d !== 20'd1048575) begin errors++; $display("FAIL unsigned_max dout: got %0d expected 1048575", dout_d); end
    checks++; if (ovf_d !== 1'b1) begin errors++; $display("FAIL unsigned_max ovf: got %b expected 1", ovf_d); end
    checks++; if (dout_w !== 20'd1015745 || ovf_w !== 1'b1) begin
      errors++; $display("FAIL wrap_max dout/ovf: got %0d/%b expected 1015745/1", dout_w, ovf_w);
    end
    xact(15'd1000, 6'd50, 2'b00, lat);
    checks++; if (dout_d !== 20'd50000) begin errors++; $display("FAIL unsigned_mid dout: got %0d expected 50000", dout_d); end
    checks++; if (ovf_d !== 1'b0) begin errors++; $display("FAIL unsigned_mid ovf: got %b expected 0", ovf_d); end
    checks++; if (dout_w !== 20'd50000 || ovf_w !== 1'b0) begin
      errors++; $display("FAIL wrap_mid dout/ovf: got %0d/%b expected 50000/0", dout_w, ovf_w);
    end
  endtask

  task automatic test_signed_sat;
    int lat;
    xact(15'h4000, 6'h20, 2'b11, lat);
    checks++; if (dout_d !== 20'd524287) begin errors++; $display("FAIL signed_max dout: got %0d expected 524287", dout_d); end
    checks++; if (ovf_d !== 1'b1) begin errors++; $display("FAIL signed_max ovf: got %b expected 1", ovf_d); end
    xact(15'h7FFF, 6'h3F, 2'b11, lat);
    checks++; if (dout_d !== 20'd1) begin errors++; $display("FAIL signed_m1m1 dout: got %0d expected 1", dout_d); end
    checks++; if (ovf_d !== 1'b0) begin errors++; $display("FAIL signed_m1m1 ovf: got %b expected 0", ovf_d); end
  endtask

  task automatic test_rounding;
    int lat;
    xact(15'd100, 6'd7, 2'b00, lat);
    checks++; if (out_valid_r !== 1'b1 || dout_r !== 20'd44) begin
      errors++; $display("FAIL round_pos dout: got %0d (valid %b) expected 44", dout_r, out_valid_r);
    end
    checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL round_pos ovf: got %b expected 0", ovf_r); end
    // -700 + 8 = -692, floor(-692/16) = -44
    xact(15'h7F9C, 6'd7, 2'b01, lat);
    checks++; if (dout_r !== 20'hFFFD4) begin errors++; $display("FAIL round_neg dout: got %h expected fffd4", dout_r); end
    checks++; if (ovf_r !== 1'b0) begin errors++; $display("FAIL round_neg ovf: got %b expected 0", ovf_r); end
  endtask

  task automatic test_back_to_back;
    int sent, got;
    logic [19:0] expv, held;
    bit stalled_prev;
    bit extra;
    sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      in_valid  = (sent < 10);
      din0 = 15'(100 + sent); din1 = 6'(sent + 1); sign_mode = 2'b00;
      #1;
      if (out_valid_d && out_ready) begin
        expv = 20'((100 + got) * (got + 1));
        checks++;
        if (dout_d !== expv || ovf_d !== 1'b0) begin
          errors++; $display("FAIL b2b result %0d: got %0d/%b expected %0d/0", got, dout_d, ovf_d, expv);
        end
        got++;
        stalled_prev = 1'b0;
      end else if (out_valid_d) begin
        checks++;
        if (in_ready_d !== 1'b0) begin errors++; $display("FAIL b2b stall in_ready: got %b expected 0", in_ready_d); end
        if (stalled_prev) begin
          checks++;
          if (dout_d !== held) begin errors++; $display("FAIL b2b stall dout: got %0d expected %0d", dout_d, held); end
        end
        held = dout_d;
        stalled_prev = 1'b1;
      end
      if (in_valid && in_ready_d) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 10) begin errors++; $display("FAIL b2b count: got %0d expected 10", got); end
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_d) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL b2b duplicate: got extra result, expected none"); end
  endtask

  task automatic test_reset_midflight;
    int lat;
    bit stale;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; din0 = 15'd10; din1 = 6'd3; sign_mode = 2'b00;
    @(negedge clk); din0 = 15'd20;
    @(negedge clk); din0 = 15'd30;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++; if (out_valid_d !== 1'b1 || dout_d !== 20'd30) begin
      errors++; $display("FAIL midflight pre-reset: got %b/%0d expected 1/30", out_valid_d, dout_d);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (out_valid_d !== 1'b0) begin errors++; $display("FAIL midflight out_valid: got %b expected 0", out_valid_d); end
    checks++; if (dout_d !== 20'd0 || ovf_d !== 1'b0) begin
      errors++; $display("FAIL midflight dout/ovf: got %0d/%b expected 0/0", dout_d, ovf_d);
    end
    @(negedge clk);
    @(negedge clk);
    ap_rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_d) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midflight stale: got stale result, expected none"); end
    xact(15'd1000, 6'd50, 2'b00, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL post-reset latency: got %0d expected 3", lat); end
    checks++; if (dout_d !== 20'd50000) begin errors++; $display("FAIL post-reset dout: got %0d expected 50000", dout_d); end
  endtask

  initial begin
    test_reset();
    test_unsigned_sat();
    test_signed_sat();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
